posit_decode_arbiter: RTL

POSIT_DECODE_ARBITER -- requirements
Module: posit_decode_arbiter

---
 rtl/posit_decode_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/posit_decode_arbiter.sv
// ============================================================================
// posit_decode_arbiter -- two requesters share one posit<8,0> decoder through
// a registered output stage. Define POSIT_ARB_ROUND_ROBIN_EN for round-robin
// arbitration (fixed A priority otherwise).
// Revision: 1.0
// ============================================================================
`default_nettype none

module posit_decode_8bit (
  input  logic [7:0]  posit,
  output logic [11:0] dposit
);

  // Output layout: {nar, zero, sign, scale+7 [3:0], fraction [4:0]}.
  // The regime is read from the bits XOR the sign; the fraction stays raw,
  // giving the two's-complement form value = (1 - 3*sign + frac) * 2^scale.
  logic       sign;
  logic [6:0] body;
  logic [6:0] body_x;
  logic       reg_bit;
  logic [2:0] run;
  logic       run_done;
  logic [3:0] scale;
  logic [6:0] shifted;

  always_comb begin
    sign     = posit[7];
    body     = posit[6:0];
    body_x   = body ^ {7{sign}};
    reg_bit  = body_x[6];
    run      = 3'd0;
    run_done = 1'b0;
    for (int i = 6; i >= 0; i--) begin
      if (!run_done && (body_x[i] == reg_bit)) begin
        run = run + 3'd1;
      end else begin
        run_done = 1'b1;
      end
    end
    scale   = reg_bit ? (4'd6 + {1'b0, run}) : (4'd7 - {1'b0, run});
    shifted = body << ({1'b0, run} + 4'd1);
    dposit  = {(posit == 8'h80), (posit == 8'h00), sign, scale, shifted[6:2]};
  end

endmodule

module posit_decode_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  input  logic [7:0]       a_posit,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [7:0]       b_posit,
  output logic             b_ready,
  output logic             out_valid,
  output logic [11:0]      out_dposit,
  output logic             out_src,
  input  logic             out_ready,
  output logic [CNT_W-1:0] dec_count
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        can_accept;
  logic        grant;
  logic [7:0]  dec_in;
  logic [11:0] dec_out;

`ifdef POSIT_ARB_ROUND_ROBIN_EN
  logic        last_src;
`endif

  posit_decode_8bit u_decode (
    .posit  (dec_in),
    .dposit (dec_out)
  );

  always_comb begin
    state_next = state;
    a_ready    = 1'b0;
    b_ready    = 1'b0;
    can_accept = (state == EMPTY) || out_ready;
    if (!rst && can_accept) begin
`ifdef POSIT_ARB_ROUND_ROBIN_EN
      // On contention the requester that did not win last time goes first.
      if (a_valid && (!b_valid || last_src)) begin
        a_ready = 1'b1;
      end else if (b_valid) begin
        b_ready = 1'b1;
      end
`else
      if (a_valid) begin
        a_ready = 1'b1;
      end else if (b_valid) begin
        b_ready = 1'b1;
      end
`endif
    end
    grant  = a_ready || b_ready;
    dec_in = b_ready ? b_posit : a_posit;
    case (state)
      EMPTY: if (grant) state_next = FULL;
      FULL:  if (out_ready && !grant) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  assign out_valid = (state == FULL);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_dposit <= 12'h000;
      out_src    <= 1'b0;
    end else if (grant) begin
      out_dposit <= dec_out;
      out_src    <= b_ready;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dec_count <= '0;
    end else if (out_valid && out_ready) begin
      dec_count <= dec_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

`ifdef POSIT_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      last_src <= 1'b1;
    end else if (grant) begin
      last_src <= b_ready;
    end
  end
`endif

endmodule

`default_nettype wire
